// File: rtl/idli_pkg.sv
// Shared types for the idli core: slice counter, memory-port owner and
// memory-arbiter state encodings.
package idli_pkg;

   localparam int unsigned CTR_W  = 2;
   localparam int unsigned WCNT_W = 3;

   // Slice index within the current 4-cycle word.
   typedef logic [CTR_W-1:0] ctr_t;

   // Which requester currently owns the SQI memory port.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_F    = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   // Memory arbiter sequencing state.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      F_SETUP = 3'd1,
      F_DATA  = 3'd2,
      D_SETUP = 3'd3,
      D_DATA  = 3'd4
   } arb_state_t;

   // Owner is a pure decode of the arbiter state.
   function automatic owner_t owner_of(arb_state_t s);
      owner_t o;
      o = OWN_NONE;
      if ((s == F_SETUP) || (s == F_DATA)) o = OWN_F;
      if ((s == D_SETUP) || (s == D_DATA)) o = OWN_D;
      return o;
   endfunction

endpackage

// File: rtl/idli_mem_arb_m.sv
// idli_mem_arb_m: owns the 2-bit slice counter and arbitrates the shared SQI
// memory port between instruction fetch (F) and EX load/store (D).
// All decisions are taken at word boundaries (ctr==3) and become visible at
// the following ctr==0.
// Ports:
//   i_marb_gck       core clock
//   i_marb_rst       synchronous active-high reset
//   o_marb_ctr       slice counter
//   i_marb_f_req     fetch wants instruction words (level)
//   i_marb_redirect  pulse: fetch stream is stale
//   i_marb_d_req     data access pending (held until d_done)
//   i_marb_d_wr      1 = store, 0 = load
//   o_marb_owner     current port owner (owner_t)
//   o_marb_setup     current word is a cmd/addr/dummy word
//   o_marb_start     pulse at ctr==0 of a new SQI transaction
//   o_marb_wr        latched d_wr while D owns the port
//   o_marb_f_vld     pulse at ctr==3: valid fetch data word completed
//   o_marb_d_done    pulse at ctr==3: D data word completed
module idli_mem_arb_m
   import idli_pkg::*;
#(
   parameter int unsigned P_SETUP_WORDS = 2,
   parameter int unsigned P_F_MIN_WORDS = 2
) (
   input  logic       i_marb_gck,
   input  logic       i_marb_rst,
   output logic [1:0] o_marb_ctr,
   input  logic       i_marb_f_req,
   input  logic       i_marb_redirect,
   input  logic       i_marb_d_req,
   input  logic       i_marb_d_wr,
   output logic [1:0] o_marb_owner,
   output logic       o_marb_setup,
   output logic       o_marb_start,
   output logic       o_marb_wr,
   output logic       o_marb_f_vld,
   output logic       o_marb_d_done
);

   localparam logic [WCNT_W-1:0] LAST_SETUP = WCNT_W'(P_SETUP_WORDS - 1);
   localparam logic [WCNT_W-1:0] F_MIN      = WCNT_W'(P_F_MIN_WORDS);
   localparam logic [WCNT_W-1:0] F_CNT_MAX  = '1;

   ctr_t              ctr_q,    ctr_d;
   arb_state_t        state_q,  state_d;
   logic [WCNT_W-1:0] wcnt_q,   wcnt_d;
   logic [WCNT_W-1:0] f_cnt_q,  f_cnt_d;
   logic              pend_q,   pend_d;
   owner_t            owner_q,  owner_d;
   logic              setup_q,  setup_d;
   logic              wr_q,     wr_d;
   logic              start_q,  start_d;
   logic              d_done_q, d_done_d;

   logic boundary;
   logic redir_eff;
   logic last_setup;
   logic enter_f;
   logic enter_d;

   assign boundary   = (ctr_q == 2'd3);
   // A redirect arriving on the boundary cycle itself counts for that boundary.
   assign redir_eff  = pend_q | i_marb_redirect;
   assign last_setup = (wcnt_q == LAST_SETUP);

   // State register and registered outputs.
   always_ff @(posedge i_marb_gck) begin
      if (i_marb_rst) begin
         ctr_q    <= '0;
         state_q  <= IDLE;
         wcnt_q   <= '0;
         f_cnt_q  <= '0;
         pend_q   <= 1'b0;
         owner_q  <= OWN_NONE;
         setup_q  <= 1'b0;
         wr_q     <= 1'b0;
         start_q  <= 1'b0;
         d_done_q <= 1'b0;
      end else begin
         ctr_q    <= ctr_d;
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         f_cnt_q  <= f_cnt_d;
         pend_q   <= pend_d;
         owner_q  <= owner_d;
         setup_q  <= setup_d;
         wr_q     <= wr_d;
         start_q  <= start_d;
         d_done_q <= d_done_d;
      end
   end

   // Next-state and next-output logic; state only moves on word boundaries.
   always_comb begin
      ctr_d    = ctr_q + 2'd1;
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      f_cnt_d  = f_cnt_q;
      enter_f  = 1'b0;
      enter_d  = 1'b0;

      if (boundary) begin
         case (state_q)
            IDLE: begin
               if (i_marb_d_req)      enter_d = 1'b1;
               else if (i_marb_f_req) enter_f = 1'b1;
            end
            F_SETUP: begin
               if (!i_marb_f_req)     state_d = IDLE;
               else if (last_setup) begin
                  if (redir_eff)      enter_f = 1'b1;
                  else                state_d = F_DATA;
               end else               wcnt_d  = wcnt_q + 3'd1;
            end
            F_DATA: begin
               if (!i_marb_f_req) begin
                  if (i_marb_d_req)   enter_d = 1'b1;
                  else                state_d = IDLE;
               end else if (redir_eff) enter_f = 1'b1;
               else if (i_marb_d_req && (f_cnt_q >= F_MIN)) enter_d = 1'b1;
               else if (f_cnt_q != F_CNT_MAX) f_cnt_d = f_cnt_q + 3'd1;
            end
            D_SETUP: begin
               if (last_setup)        state_d = D_DATA;
               else                   wcnt_d  = wcnt_q + 3'd1;
            end
            D_DATA: begin
               // F goes before a back-to-back D.
               if (i_marb_f_req)      enter_f = 1'b1;
               else if (i_marb_d_req) enter_d = 1'b1;
               else                   state_d = IDLE;
            end
            default:                  state_d = IDLE;
         endcase
      end

      // Transaction entry (including restarts) resets the word counters.
      if (enter_f) begin
         state_d = F_SETUP;
         wcnt_d  = '0;
         f_cnt_d = '0;
      end
      if (enter_d) begin
         state_d = D_SETUP;
         wcnt_d  = '0;
      end

      // Sticky redirect; a redirect in the entry cycle itself survives the clear.
      pend_d   = i_marb_redirect | (pend_q & ~enter_f);

      owner_d  = owner_of(state_d);
      setup_d  = (state_d == F_SETUP) || (state_d == D_SETUP);
      start_d  = enter_f | enter_d;
      d_done_d = (ctr_q == 2'd2) && (state_q == D_DATA);

      wr_d = 1'b0;
      if (enter_d)                                      wr_d = i_marb_d_wr;
      else if ((state_d == D_SETUP) || (state_d == D_DATA)) wr_d = wr_q;
   end

   assign o_marb_ctr    = ctr_q;
   assign o_marb_owner  = owner_q;
   assign o_marb_setup  = setup_q;
   assign o_marb_start  = start_q;
   assign o_marb_wr     = wr_q;
   assign o_marb_d_done = d_done_q;

   // Combinational: a redirect on the completing cycle must suppress the stale word.
   assign o_marb_f_vld  = boundary && (state_q == F_DATA) && !pend_q && !i_marb_redirect;

endmodule

// File: tb/tb_idli_mem_arb_m.sv
// Directed bench for idli_mem_arb_m with an event scoreboard.
module tb_idli_mem_arb_m;
   import idli_pkg::*;

   localparam int K_START = 0;
   localparam int K_FVLD  = 1;
   localparam int K_DONE  = 2;

   typedef struct {
      int         kind;
      int         cyc;
      logic [1:0] own;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] ctr;
   logic       f_req, redirect, d_req, d_wr;
   logic [1:0] owner;
   logic       setup, start, wr, f_vld, d_done;

   int  cyc    = 0;
   int  t0     = 0;
   int  checks = 0;
   int  errors = 0;
   ev_t exp_q[$];

   idli_mem_arb_m #(.P_SETUP_WORDS(2), .P_F_MIN_WORDS(2)) dut (
      .i_marb_gck      (clk),
      .i_marb_rst      (rst),
      .o_marb_ctr      (ctr),
      .i_marb_f_req    (f_req),
      .i_marb_redirect (redirect),
      .i_marb_d_req    (d_req),
      .i_marb_d_wr     (d_wr),
      .o_marb_owner    (owner),
      .o_marb_setup    (setup),
      .o_marb_start    (start),
      .o_marb_wr       (wr),
      .o_marb_f_vld    (f_vld),
      .o_marb_d_done   (d_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic expect_ev(input int kind, input int c, input logic [1:0] own);
      exp_q.push_back('{kind: kind, cyc: t0 + c, own: own});
   endtask

   // Advance to relative cycle t, landing 1 time unit after its opening edge.
   task automatic go(input int t);
      while (cyc < t0 + t) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Scoreboard: every start / f_vld / d_done pulse must match the next expectation.
   always @(negedge clk) begin
      int  kind;
      int  n;
      ev_t e;
      if (!rst) begin
         n    = int'(start) + int'(f_vld) + int'(d_done);
         kind = -1;
         if (start)       kind = K_START;
         else if (f_vld)  kind = K_FVLD;
         else if (d_done) kind = K_DONE;
         if (n > 1) chk("one_event_per_cycle", 32'(n), 32'd1);
         if (kind >= 0) begin
            if (exp_q.size() == 0) begin
               chk("spurious_event_at_cycle", 32'(cyc - t0), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("ev_kind",  32'(kind), 32'(e.kind));
               chk("ev_cycle", 32'(cyc - t0), 32'(e.cyc - t0));
               chk("ev_owner", 32'(owner), 32'(e.own));
            end
         end
      end
   end

   initial begin
      rst = 1'b1; f_req = 1'b0; redirect = 1'b0; d_req = 1'b0; d_wr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      t0  = cyc;
      rst = 1'b0;

      // Reset state
      chk("rst_ctr",    32'(ctr),    32'd0);
      chk("rst_owner",  32'(owner),  32'(OWN_NONE));
      chk("rst_setup",  32'(setup),  32'd0);
      chk("rst_start",  32'(start),  32'd0);
      chk("rst_wr",     32'(wr),     32'd0);
      chk("rst_f_vld",  32'(f_vld),  32'd0);
      chk("rst_d_done", 32'(d_done), 32'd0);

      // Fetch stream, D preemption after F_MIN words, redirect, fetch drop
      f_req = 1'b1;
      expect_ev(K_START, 4,  OWN_F);
      expect_ev(K_FVLD,  15, OWN_F);
      expect_ev(K_FVLD,  19, OWN_F);
      expect_ev(K_FVLD,  23, OWN_F);
      expect_ev(K_START, 24, OWN_D);
      expect_ev(K_DONE,  35, OWN_D);
      expect_ev(K_START, 36, OWN_F);
      expect_ev(K_START, 48, OWN_F);
      expect_ev(K_FVLD,  59, OWN_F);
      expect_ev(K_FVLD,  63, OWN_F);
      go(3);  chk("idle_ctr3_owner", 32'(owner), 32'(OWN_NONE));
              chk("ctr_at_3",        32'(ctr),   32'd3);
      go(4);  chk("f_owner_c4",  32'(owner), 32'(OWN_F));
              chk("f_setup_c4",  32'(setup), 32'd1);
              chk("ctr_wrap_c4", 32'(ctr),   32'd0);
      go(11); chk("f_setup_c11", 32'(setup), 32'd1);
      go(12); chk("f_setup_c12", 32'(setup), 32'd0);
      go(13); d_req = 1'b1; d_wr = 1'b1;
      go(20); chk("no_preempt_owner", 32'(owner), 32'(OWN_F));
              chk("no_preempt_wr",    32'(wr),    32'd0);
      go(24); chk("d_owner_c24", 32'(owner), 32'(OWN_D));
              chk("d_setup_c24", 32'(setup), 32'd1);
              chk("d_wr_c24",    32'(wr),    32'd1);
      go(32); chk("d_data_setup", 32'(setup), 32'd0);
              chk("d_data_wr",    32'(wr),    32'd1);
      go(35); d_req = 1'b0;
      go(36); chk("f_back_owner", 32'(owner), 32'(OWN_F));
              chk("f_back_wr",    32'(wr),    32'd0);
      go(45); redirect = 1'b1;
      go(46); redirect = 1'b0;
      go(48); chk("restart_setup", 32'(setup), 32'd1);
      go(61); f_req = 1'b0;
      go(64); chk("f_drop_idle", 32'(owner), 32'(OWN_NONE));

      // Simultaneous requests: D first, then F wins over a held d_req;
      // redirect during D_SETUP is deferred to the next F entry.
      f_req = 1'b1; d_req = 1'b1; d_wr = 1'b0;
      expect_ev(K_START, 68,  OWN_D);
      expect_ev(K_DONE,  79,  OWN_D);
      expect_ev(K_START, 80,  OWN_F);
      expect_ev(K_FVLD,  91,  OWN_F);
      expect_ev(K_FVLD,  95,  OWN_F);
      expect_ev(K_FVLD,  99,  OWN_F);
      expect_ev(K_START, 100, OWN_D);
      expect_ev(K_DONE,  111, OWN_D);
      expect_ev(K_START, 112, OWN_F);
      expect_ev(K_FVLD,  123, OWN_F);
      expect_ev(K_FVLD,  127, OWN_F);
      go(68);  chk("both_d_owner", 32'(owner), 32'(OWN_D));
               chk("both_d_wr",    32'(wr),    32'd0);
      go(80);  chk("fair_f_owner", 32'(owner), 32'(OWN_F));
               d_wr = 1'b1;
      go(100); chk("d2_wr", 32'(wr), 32'd1);
      go(102); redirect = 1'b1;
      go(103); redirect = 1'b0;
      go(108); chk("d2_data_owner", 32'(owner), 32'(OWN_D));
               chk("d2_data_setup", 32'(setup), 32'd0);
      go(111); d_req = 1'b0;
      go(112); chk("after_d2_owner", 32'(owner), 32'(OWN_F));
               chk("after_d2_wr",    32'(wr),    32'd0);
      go(124); f_req = 1'b0;
      go(128); chk("idle_c128", 32'(owner), 32'(OWN_NONE));

      // Synchronous reset in the middle of D_DATA
      d_req = 1'b1; d_wr = 1'b1;
      expect_ev(K_START, 132, OWN_D);
      go(132); chk("d3_wr", 32'(wr), 32'd1);
      go(142); chk("pre_rst_ctr",   32'(ctr),   32'd2);
               chk("pre_rst_owner", 32'(owner), 32'(OWN_D));
               rst = 1'b1;
      go(143); chk("mid_rst_ctr",    32'(ctr),    32'd0);
               chk("mid_rst_owner",  32'(owner),  32'(OWN_NONE));
               chk("mid_rst_wr",     32'(wr),     32'd0);
               chk("mid_rst_done",   32'(d_done), 32'd0);
               chk("mid_rst_setup",  32'(setup),  32'd0);
               rst = 1'b0;
      expect_ev(K_START, 147, OWN_D);
      expect_ev(K_DONE,  158, OWN_D);
      go(147); chk("rearb_wr", 32'(wr), 32'd1);
      go(158); d_req = 1'b0;
      go(159); chk("final_idle", 32'(owner), 32'(OWN_NONE));
      go(170); chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
